// File: rtl/mips_reg_file_param.sv
`timescale 1ns/1ps
// mips_reg_file_param
// Parametrised MIPS general-purpose register file with a HI/LO pair for the
// mult/div unit, optional write-to-read forwarding and a post-reset clear sweep.
//
// Ports:
//   CLK           clock, all state updates on the rising edge
//   reset         synchronous active-high reset, restarts the clear sweep
//   ready         high once every register has been cleared (RUN state)
//   RegWrite      GPR write enable
//   WriteAddress  GPR index to write (index 0 is discarded)
//   DataIn        GPR write data
//   RdAddr        packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   RdData        packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HiLoWrite     write enable for HI and LO together
//   HiIn, LoIn    HI/LO write data
//   HiOut, LoOut  registered HI/LO values (zero while clearing)
module mips_reg_file_param #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_READ     = 2,
    parameter int unsigned WRITE_BYPASS = 1
) (
    input  logic                           CLK,
    input  logic                           reset,
    output logic                           ready,
    input  logic                           RegWrite,
    input  logic [ADDR_WIDTH-1:0]          WriteAddress,
    input  logic [DATA_WIDTH-1:0]          DataIn,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] RdAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] RdData,
    input  logic                           HiLoWrite,
    input  logic [DATA_WIDTH-1:0]          HiIn,
    input  logic [DATA_WIDTH-1:0]          LoIn,
    output logic [DATA_WIDTH-1:0]          HiOut,
    output logic [DATA_WIDTH-1:0]          LoOut
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_WIDTH-1:0] hi_q, lo_q;
    logic                  gpr_we;
    logic                  hilo_we;

    // Register 0 is hardwired to zero, so no storage is kept for it.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StClear;
            clr_idx_q <= FIRST_IDX;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic: sweep one entry per edge, leave CLEAR after the last one
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = StRun;
            end
        end
    end

    // Outputs of the FSM: writes are only honoured once the sweep is done
    always_comb begin
        ready   = (state_q == StRun);
        gpr_we  = ready && RegWrite && (WriteAddress != '0);
        hilo_we = ready && HiLoWrite;
    end

    // GPR array: cleared by the sweep, written by writeback in RUN
    always_ff @(posedge CLK) begin
        if (!reset) begin
            if (state_q == StClear) begin
                regs[clr_idx_q] <= '0;
            end else if (gpr_we) begin
                regs[WriteAddress] <= DataIn;
            end
        end
    end

    // HI/LO pair
    always_ff @(posedge CLK) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            hi_q <= HiIn;
            lo_q <= LoIn;
        end
    end

    assign HiOut = ready ? hi_q : '0;
    assign LoOut = ready ? lo_q : '0;

    // Read ports, each with its own forwarding compare
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;

        assign addr = RdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = '0;
            if (ready && (addr != '0)) begin
                data = regs[addr];
            end
            // gpr_we already excludes address 0 and the CLEAR state
            if ((WRITE_BYPASS != 0) && gpr_we && (addr == WriteAddress)) begin
                data = DataIn;
            end
        end

        assign RdData[i*DATA_WIDTH +: DATA_WIDTH] = data;
    end

endmodule

// File: tb/tb_mips_reg_file_param.sv
`timescale 1ns/1ps
// Directed bench for mips_reg_file_param: a default instance with forwarding,
// a forwarding-disabled instance sharing its inputs, and a small 4-port
// 16-bit / 8-entry instance.
module tb_mips_reg_file_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared inputs for the two default-size instances
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteAddress;
    logic [31:0] DataIn;
    logic [9:0]  RdAddr;
    logic        HiLoWrite;
    logic [31:0] HiIn, LoIn;

    logic        rdy_b1, rdy_b0;
    logic [63:0] rd_b1, rd_b0;
    logic [31:0] hi_b1, lo_b1, hi_b0, lo_b0;

    // Small configuration
    logic        s_reset;
    logic        s_we;
    logic [2:0]  s_wa;
    logic [15:0] s_din;
    logic [11:0] s_raddr;
    logic [63:0] s_rd;
    logic        s_ready;
    logic        s_hilo_we;
    logic [15:0] s_hi_in, s_lo_in, s_hi, s_lo;

    int errors = 0;
    int checks = 0;

    mips_reg_file_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .WRITE_BYPASS(1)
    ) u_b1 (
        .CLK(CLK), .reset(reset), .ready(rdy_b1), .RegWrite(RegWrite),
        .WriteAddress(WriteAddress), .DataIn(DataIn), .RdAddr(RdAddr), .RdData(rd_b1),
        .HiLoWrite(HiLoWrite), .HiIn(HiIn), .LoIn(LoIn), .HiOut(hi_b1), .LoOut(lo_b1)
    );

    mips_reg_file_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .WRITE_BYPASS(0)
    ) u_b0 (
        .CLK(CLK), .reset(reset), .ready(rdy_b0), .RegWrite(RegWrite),
        .WriteAddress(WriteAddress), .DataIn(DataIn), .RdAddr(RdAddr), .RdData(rd_b0),
        .HiLoWrite(HiLoWrite), .HiIn(HiIn), .LoIn(LoIn), .HiOut(hi_b0), .LoOut(lo_b0)
    );

    mips_reg_file_param #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(4), .WRITE_BYPASS(1)
    ) u_small (
        .CLK(CLK), .reset(s_reset), .ready(s_ready), .RegWrite(s_we),
        .WriteAddress(s_wa), .DataIn(s_din), .RdAddr(s_raddr), .RdData(s_rd),
        .HiLoWrite(s_hilo_we), .HiIn(s_hi_in), .LoIn(s_lo_in), .HiOut(s_hi), .LoOut(s_lo)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Read every address on both ports of both default instances; all must be 0
    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            RdAddr = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (rd_b1 !== 64'h0) begin
                errors++;
                $display("FAIL %s_b1 r%0d: got %h expected 0", tag, a, rd_b1);
            end
            checks++;
            if (rd_b0 !== 64'h0) begin
                errors++;
                $display("FAIL %s_b0 r%0d: got %h expected 0", tag, a, rd_b0);
            end
        end
    endtask

    // Reset sweep, with GPR and HI/LO writes held asserted the whole time
    task automatic test_reset();
        logic exp;
        reset = 1'b1; s_reset = 1'b1;
        tick();
        tick();
        checks++;
        if (rdy_b1 !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", rdy_b1);
        end
        checks++;
        if (hi_b1 !== 32'h0 || lo_b1 !== 32'h0) begin
            errors++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_b1, lo_b1);
        end
        reset = 1'b0; s_reset = 1'b0;
        RegWrite = 1'b1; WriteAddress = 5'd3; DataIn = 32'hFFFF_FFFF;
        HiLoWrite = 1'b1; HiIn = 32'hFFFF_FFFF; LoIn = 32'hFFFF_FFFF;
        RdAddr = {5'd3, 5'd3};
        for (int e = 1; e <= 31; e++) begin
            tick();
            exp = (e == 31);
            checks++;
            if (rdy_b1 !== exp) begin
                errors++; $display("FAIL sweep_ready edge %0d: got %b expected %b", e, rdy_b1, exp);
            end
            checks++;
            if (rdy_b0 !== exp) begin
                errors++; $display("FAIL sweep_ready_b0 edge %0d: got %b expected %b", e, rdy_b0, exp);
            end
            exp = (e >= 7);
            checks++;
            if (s_ready !== exp) begin
                errors++; $display("FAIL small_ready edge %0d: got %b expected %b", e, s_ready, exp);
            end
            if (e < 31) begin
                checks++;
                if (rd_b1 !== 64'h0) begin
                    errors++; $display("FAIL sweep_read edge %0d: got %h expected 0", e, rd_b1);
                end
            end
        end
        RegWrite = 1'b0; HiLoWrite = 1'b0;
        #1;
        checks++;
        if (hi_b1 !== 32'h0 || lo_b1 !== 32'h0 || hi_b0 !== 32'h0 || lo_b0 !== 32'h0) begin
            errors++;
            $display("FAIL sweep_hilo_ignored: got %h/%h expected 0/0", hi_b1, lo_b1);
        end
        check_all_zero("after_sweep");
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteAddress = 5'd5; DataIn = 32'hDEAD_BEEF;
        RdAddr = {5'd6, 5'd5};
        #1;
        checks++;
        if (rd_b1[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fwd_r5: got %h expected deadbeef", rd_b1[31:0]);
        end
        checks++;
        if (rd_b0[31:0] !== 32'h0) begin
            errors++; $display("FAIL nofwd_r5: got %h expected 0", rd_b0[31:0]);
        end
        checks++;
        if (rd_b1[63:32] !== 32'h0) begin
            errors++; $display("FAIL fwd_other_port: got %h expected 0", rd_b1[63:32]);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd_b1[31:0] !== 32'hDEAD_BEEF || rd_b0[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_r5: got %h/%h expected deadbeef", rd_b1[31:0], rd_b0[31:0]);
        end
        RegWrite = 1'b1; WriteAddress = 5'd0; DataIn = 32'h1234_5678;
        RdAddr = {5'd5, 5'd0};
        #1;
        checks++;
        if (rd_b1[31:0] !== 32'h0) begin
            errors++; $display("FAIL r0_no_fwd: got %h expected 0", rd_b1[31:0]);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd_b1[31:0] !== 32'h0 || rd_b0[31:0] !== 32'h0) begin
            errors++; $display("FAIL r0_write: got %h/%h expected 0", rd_b1[31:0], rd_b0[31:0]);
        end
        checks++;
        if (rd_b1[63:32] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL r0_side_effect: got %h expected deadbeef", rd_b1[63:32]);
        end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteAddress = 5'd7; DataIn = 32'hA5A5_A5A5;
        RdAddr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_b1 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            errors++; $display("FAIL bypass_on: got %h expected a5a5a5a5a5a5a5a5", rd_b1);
        end
        checks++;
        if (rd_b0 !== 64'h0) begin
            errors++; $display("FAIL bypass_off: got %h expected 0", rd_b0);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd_b0 !== 64'hA5A5_A5A5_A5A5_A5A5 || rd_b1 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            errors++; $display("FAIL bypass_after_edge: got %h/%h expected a5a5..", rd_b1, rd_b0);
        end
    endtask

    task automatic test_hilo();
        HiLoWrite = 1'b1; HiIn = 32'h1; LoIn = 32'hFFFF_FFFE;
        RegWrite = 1'b1; WriteAddress = 5'd9; DataIn = 32'h42;
        RdAddr = {5'd0, 5'd9};
        #1;
        checks++;
        if (hi_b1 !== 32'h0 || lo_b1 !== 32'h0) begin
            errors++; $display("FAIL hilo_before_edge: got %h/%h expected 0/0", hi_b1, lo_b1);
        end
        tick();
        HiLoWrite = 1'b0; RegWrite = 1'b0;
        #1;
        checks++;
        if (hi_b1 !== 32'h1 || hi_b0 !== 32'h1) begin
            errors++; $display("FAIL hi: got %h/%h expected 1", hi_b1, hi_b0);
        end
        checks++;
        if (lo_b1 !== 32'hFFFF_FFFE || lo_b0 !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL lo: got %h/%h expected fffffffe", lo_b1, lo_b0);
        end
        checks++;
        if (rd_b1[31:0] !== 32'h42 || rd_b0[31:0] !== 32'h42) begin
            errors++; $display("FAIL parallel_r9: got %h/%h expected 42", rd_b1[31:0], rd_b0[31:0]);
        end
    endtask

    task automatic test_small_config();
        logic [15:0] exp;
        for (int i = 1; i <= 4; i++) begin
            s_we = 1'b1; s_wa = 3'(i); s_din = 16'(16'h1111 * i);
            tick();
        end
        s_we = 1'b1; s_wa = 3'd7; s_din = 16'hBEEF;
        tick();
        s_we = 1'b0;
        s_raddr = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            exp = 16'(16'h1111 * (p + 1));
            checks++;
            if (s_rd[p*16 +: 16] !== exp) begin
                errors++; $display("FAIL small_port%0d: got %h expected %h", p, s_rd[p*16 +: 16], exp);
            end
        end
        s_raddr = {3'd7, 3'd0, 3'd7, 3'd2};
        #1;
        checks++;
        if (s_rd !== 64'hBEEF_0000_BEEF_2222) begin
            errors++; $display("FAIL small_mixed: got %h expected beef0000beef2222", s_rd);
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        for (int a = 1; a < 32; a++) begin
            RegWrite = 1'b1; WriteAddress = 5'(a); DataIn = 32'h0101_0101 * a;
            tick();
        end
        RegWrite = 1'b0;
        RdAddr = {5'd31, 5'd1};
        #1;
        checks++;
        if (rd_b1 !== 64'h1F1F_1F1F_0101_0101) begin
            errors++; $display("FAIL fill: got %h expected 1f1f1f1f01010101", rd_b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (rdy_b1 !== 1'b0 || hi_b1 !== 32'h0 || lo_b1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b hi=%h lo=%h expected 0/0/0", rdy_b1, hi_b1, lo_b1);
        end
        for (int e = 1; e <= 31; e++) begin
            tick();
            exp = (e == 31);
            checks++;
            if (rdy_b1 !== exp) begin
                errors++; $display("FAIL resweep_ready edge %0d: got %b expected %b", e, rdy_b1, exp);
            end
        end
        check_all_zero("after_resweep");
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteAddress = '0; DataIn = '0; RdAddr = '0;
        HiLoWrite = 1'b0; HiIn = '0; LoIn = '0;
        s_reset = 1'b1; s_we = 1'b0; s_wa = '0; s_din = '0; s_raddr = '0;
        s_hilo_we = 1'b0; s_hi_in = '0; s_lo_in = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_hilo();
        test_small_config();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
